// File: rtl/wcoder_stream.sv
// Camera pixel coder: samples vsync/href/din, tags SOF/EOL, buffers in a FWFT FIFO.
// Optional WCODER_LINE_SUM_EN adds a per-line pixel sum output.
module wcoder_stream #(
  parameter int PIX_W  = 8,
  parameter int DEPTH  = 32,
  parameter int LCNT_W = 11
) (
  input  logic                       pclk,
  input  logic                       rst,
  input  logic                       vsync,
  input  logic                       href,
  input  logic [PIX_W-1:0]           din,
  input  logic                       rd_en,
  output logic                       ready,
  output logic [PIX_W-1:0]           dout,
  output logic                       dout_sof,
  output logic                       dout_eol,
  output logic [$clog2(DEPTH):0]     level,
  output logic [LCNT_W-1:0]          line_len,
  output logic [LCNT_W-1:0]          line_cnt,
  output logic                       overflow
`ifdef WCODER_LINE_SUM_EN
  ,
  output logic [PIX_W+LCNT_W-1:0]    line_sum,
  output logic                       line_sum_valid
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic             sof;
    logic             eol;
    logic [PIX_W-1:0] data;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             head;
  entry_t             wr_entry;

  logic               hold_v_q, hold_v_d;
  logic               hold_sof_q, hold_sof_d;
  logic [PIX_W-1:0]   hold_data_q, hold_data_d;
  logic               sof_pending_q, sof_pending_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic [LCNT_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [LCNT_W-1:0]  line_len_q, line_len_d;
  logic [LCNT_W-1:0]  line_cnt_q, line_cnt_d;
  logic               overflow_q, overflow_d;

  logic               line_end, capture, pop, full, wr_en, drop, eol_commit;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    line_end      = ~href | vsync;
    capture       = href & ~vsync;
    pop           = rd_en & (level_q != '0);
    full          = (level_q == LW'(DEPTH));
    eol_commit    = hold_v_q & line_end;
    wr_en         = hold_v_q & (~full | pop);
    drop          = hold_v_q & full & ~pop;
    wr_entry      = '{sof: hold_sof_q, eol: line_end, data: hold_data_q};

    hold_v_d      = capture;
    hold_sof_d    = hold_sof_q;
    hold_data_d   = hold_data_q;
    sof_pending_d = sof_pending_q;
    if (capture) begin
      hold_sof_d    = sof_pending_q;
      hold_data_d   = din;
      sof_pending_d = 1'b0;
    end
    if (vsync) sof_pending_d = 1'b1;

    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // Pixel count saturates; it is cleared by a line close or a frame start.
    pix_cnt_d = pix_cnt_q;
    if (vsync || eol_commit)              pix_cnt_d = '0;
    else if (capture && pix_cnt_q != '1)  pix_cnt_d = pix_cnt_q + 1'b1;

    line_len_d = eol_commit ? pix_cnt_q : line_len_q;
    line_cnt_d = line_cnt_q;
    if (vsync)           line_cnt_d = '0;
    else if (eol_commit) line_cnt_d = line_cnt_q + 1'b1;

    // A drop on the frame-start edge still records the loss.
    overflow_d = drop | (overflow_q & ~vsync);
  end

  always_ff @(posedge pclk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      hold_v_q      <= 1'b0;
      hold_sof_q    <= 1'b0;
      hold_data_q   <= '0;
      sof_pending_q <= 1'b1;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      pix_cnt_q     <= '0;
      line_len_q    <= '0;
      line_cnt_q    <= '0;
      overflow_q    <= 1'b0;
    end else begin
      hold_v_q      <= hold_v_d;
      hold_sof_q    <= hold_sof_d;
      hold_data_q   <= hold_data_d;
      sof_pending_q <= sof_pending_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      pix_cnt_q     <= pix_cnt_d;
      line_len_q    <= line_len_d;
      line_cnt_q    <= line_cnt_d;
      overflow_q    <= overflow_d;
    end
  end

  // NOTE: the storage array is not reset; the head is masked to zero while the FIFO is empty instead.
  always_ff @(posedge pclk) begin
    if (!rst && wr_en) mem[wr_ptr_q] <= wr_entry;
  end

  assign head     = mem[rd_ptr_q];
  assign ready    = (level_q != '0);
  assign dout     = ready ? head.data : '0;
  assign dout_sof = ready & head.sof;
  assign dout_eol = ready & head.eol;
  assign level    = level_q;
  assign line_len = line_len_q;
  assign line_cnt = line_cnt_q;
  assign overflow = overflow_q;

`ifdef WCODER_LINE_SUM_EN
  localparam int SW = PIX_W + LCNT_W;

  logic [SW-1:0] acc_q, acc_d;
  logic [SW-1:0] line_sum_q, line_sum_d;
  logic          line_sum_valid_q, line_sum_valid_d;

  // Pixels accumulate as they leave the hold register, so FIFO drops are still summed.
  always_comb begin
    acc_d            = acc_q;
    line_sum_d       = line_sum_q;
    line_sum_valid_d = eol_commit;
    if (eol_commit)    line_sum_d = acc_q + SW'(hold_data_q);
    if (vsync || eol_commit) acc_d = '0;
    else if (hold_v_q)       acc_d = acc_q + SW'(hold_data_q);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      acc_q            <= '0;
      line_sum_q       <= '0;
      line_sum_valid_q <= 1'b0;
    end else begin
      acc_q            <= acc_d;
      line_sum_q       <= line_sum_d;
      line_sum_valid_q <= line_sum_valid_d;
    end
  end

  assign line_sum       = line_sum_q;
  assign line_sum_valid = line_sum_valid_q;
`endif

endmodule

// File: tb/tb_wcoder_stream.sv
// Scoreboard bench for wcoder_stream: directed lines push expected pops, a negedge monitor compares.
module tb_wcoder_stream;
  localparam int PIX_W  = 8;
  localparam int DEPTH  = 32;
  localparam int LCNT_W = 11;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              pclk = 1'b0;
  logic              rst = 1'b1, vsync = 1'b0, href = 1'b0, rd_en = 1'b0;
  logic [PIX_W-1:0]  din = '0;
  logic              ready, dout_sof, dout_eol, overflow;
  logic [PIX_W-1:0]  dout;
  logic [LW-1:0]     level;
  logic [LCNT_W-1:0] line_len, line_cnt;
`ifdef WCODER_LINE_SUM_EN
  logic [PIX_W+LCNT_W-1:0] line_sum;
  logic                    line_sum_valid;
`endif

  wcoder_stream #(.PIX_W(PIX_W), .DEPTH(DEPTH), .LCNT_W(LCNT_W)) dut (
    .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .din(din), .rd_en(rd_en),
    .ready(ready), .dout(dout), .dout_sof(dout_sof), .dout_eol(dout_eol),
    .level(level), .line_len(line_len), .line_cnt(line_cnt), .overflow(overflow)
`ifdef WCODER_LINE_SUM_EN
    , .line_sum(line_sum), .line_sum_valid(line_sum_valid)
`endif
  );

  always #5 pclk = ~pclk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [PIX_W+1:0] sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic push(input bit sof, input bit eol, input int data);
    logic [PIX_W-1:0] d;
    d = data[PIX_W-1:0];
    sb.push_back({sof, eol, d});
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    href  = 1'b0;
    tick();
    vsync = 1'b0;
  endtask

  task automatic drain(input string name);
    rd_en = 1'b1;
    href  = 1'b0;
    for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
    check({name, "_sb_empty"}, sb.size(), 0);
    check({name, "_level0"}, level, 0);
  endtask

  // Monitor: compares the FWFT head on every cycle a pop will be taken.
  always @(negedge pclk) begin
    logic [PIX_W+1:0] e;
    if (!rst && rd_en && ready) begin
      if (sb.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_pop: got %0d, expected no entry (t=%0t)", dout, $time);
      end else begin
        e = sb.pop_front();
        check("pop_data", dout, e[PIX_W-1:0]);
        check("pop_sof", dout_sof, e[PIX_W+1]);
        check("pop_eol", dout_eol, e[PIX_W]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset held while inputs toggle.
    href = 1'b1;
    for (int i = 0; i < 2; i++) begin
      din = PIX_W'(i + 5);
      tick();
      href = ~href;
      check("rst_ready", ready, 0);
      check("rst_level", level, 0);
      check("rst_line_cnt", line_cnt, 0);
      check("rst_overflow", overflow, 0);
      check("rst_dout_sof", dout_sof, 0);
    end
    rst  = 1'b0;
    href = 1'b0;
    tick();
    check("post_rst_ready", ready, 0);
    check("post_rst_level", level, 0);
    check("post_rst_overflow", overflow, 0);

    // Frame: 3 lines x 21 pixels, continuous read.
    rd_en = 1'b1;
    for (int l = 0; l < 3; l++) begin
      for (int p = 0; p < 21; p++) begin
        href = 1'b1;
        din  = PIX_W'(p + l + 1);
        push(l == 0 && p == 0, p == 20, p + l + 1);
        tick();
      end
      href = 1'b0;
      tick();
      check("frame_line_len", line_len, 21);
      check("frame_line_cnt", line_cnt, l + 1);
      tick();
    end
    drain("frame");
    check("frame_line_cnt_final", line_cnt, 3);
    check("frame_overflow", overflow, 0);

    // Overflow: 40-pixel line with no reads.
    rd_en = 1'b0;
    vsync_pulse();
    for (int i = 0; i < 40; i++) begin
      href = 1'b1;
      din  = PIX_W'(i);
      if (i < 32) push(i == 0, 1'b0, i);
      tick();
    end
    href = 1'b0;
    tick();
    check("ovf_level", level, 32);
    check("ovf_flag", overflow, 1);
    check("ovf_line_len", line_len, 40);
    check("ovf_line_cnt", line_cnt, 1);
    drain("ovf");
    check("ovf_sticky", overflow, 1);

    // Full FIFO with simultaneous read and write.
    rd_en = 1'b0;
    vsync_pulse();
    check("full_ovf_cleared", overflow, 0);
    for (int i = 0; i < 32; i++) begin
      href = 1'b1;
      din  = PIX_W'(100 + i);
      push(i == 0, i == 31, 100 + i);
      tick();
    end
    href = 1'b0;
    tick();
    check("full_level_fill", level, 32);
    for (int i = 0; i < 10; i++) begin
      href  = 1'b1;
      din   = PIX_W'(200 + i);
      rd_en = (i != 0);
      push(1'b0, i == 9, 200 + i);
      tick();
      check("full_level_rw", level, 32);
      check("full_overflow_rw", overflow, 0);
    end
    href  = 1'b0;
    rd_en = 1'b1;
    tick();
    check("full_level_eol", level, 32);
    drain("full");
    check("full_overflow_end", overflow, 0);

    // vsync arriving after the 5th pixel of line 1.
    rd_en = 1'b1;
    vsync_pulse();
    for (int i = 0; i < 4; i++) begin
      href = 1'b1;
      din  = PIX_W'(50 + i);
      push(i == 0, i == 3, 50 + i);
      tick();
    end
    href = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      href = 1'b1;
      din  = PIX_W'(60 + i);
      push(1'b0, i == 4, 60 + i);
      tick();
    end
    vsync = 1'b1;
    din   = 8'd99;
    tick();
    check("vs_line_cnt", line_cnt, 0);
    check("vs_line_len", line_len, 5);
    vsync = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din = PIX_W'(70 + i);
      push(i == 0, i == 2, 70 + i);
      tick();
    end
    href = 1'b0;
    tick();
    check("vs_line_cnt_after", line_cnt, 1);
    check("vs_line_len_after", line_len, 3);
    drain("vs");

`ifdef WCODER_LINE_SUM_EN
    // Line sum of 1..21.
    rd_en = 1'b1;
    vsync_pulse();
    for (int i = 1; i <= 21; i++) begin
      href = 1'b1;
      din  = PIX_W'(i);
      push(i == 1, i == 21, i);
      tick();
      check("sum_valid_idle", line_sum_valid, 0);
    end
    href = 1'b0;
    tick();
    check("sum_valid_pulse", line_sum_valid, 1);
    check("sum_value", line_sum, 231);
    tick();
    check("sum_valid_single", line_sum_valid, 0);
    check("sum_value_hold", line_sum, 231);
    drain("sum");
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/wcoder_stream.md
Name: wcoder_stream

Overview:
- Parametrised successor to the camera-side pixel coder.
- Samples a parallel camera pixel bus (vsync/href/din) on pclk and tags each pixel with start-of-frame and end-of-line flags.
- Buffers tagged pixels in a first-word-fall-through FIFO drained by a downstream ready/rd_en handshake, and reports line length, line count and sticky overflow.
- Sits between the sensor pins and the weight/packing logic, all in the pclk domain.

Parameters:
PIX_W, 8, pixel width in bits
DEPTH, 32, FIFO entries; power of two, >=4
LCNT_W, 11, width of pixel-per-line and line counters

Ports:
pclk  input  1  pixel clock; all logic on rising edge
rst  input  1  synchronous active-high reset
vsync  input  1  frame start; active high, level
href  input  1  line valid; din captured while high
din  input  PIX_W  pixel data
rd_en  input  1  consumer pops head entry when ready=1
ready  output  1  FIFO non-empty; head entry valid
dout  output  PIX_W  head pixel (FWFT)
dout_sof  output  1  head pixel is first pixel of frame
dout_eol  output  1  head pixel is last pixel of its line
level  output  clog2(DEPTH)+1  current FIFO occupancy
line_len  output  LCNT_W  pixel count of last completed line
line_cnt  output  LCNT_W  completed lines since vsync
overflow  output  1  sticky: a pixel was dropped

Behaviour:
- Reset (rst=1 at edge): FIFO emptied, hold register invalid, ready=0, dout/dout_sof/dout_eol=0, level=0, line_len=0, line_cnt=0, overflow=0, sof_pending=1.
- Capture: at each edge with href=1 and vsync=0, din goes into a one-entry hold register (hold_v=1), tagged sof=sof_pending; sof_pending then clears.
- Hold commit: on an edge where hold_v=1, the held pixel is written to the FIFO. eol=1 if the same edge sees href=0 or vsync=1 (line ended); otherwise eol=0 and the new din refills the hold register.
- Latency: pixel sampled at edge N is in the FIFO after edge N+1. It appears on dout with ready=1 no earlier than after edge N+1 (FIFO empty case).
- Line tracking: pix counter increments per captured pixel and saturates at 2^LCNT_W-1. At an eol commit: line_len <= pix counter, line_cnt increments (wraps), pix counter clears.
- vsync=1 at an edge: sof_pending=1, line_cnt=0, pix counter=0, overflow=0. No pixel is captured that edge. A valid hold pixel commits with eol=1, so an aborted line is closed. The FIFO is not flushed.
- Read: rd_en=1 and ready=1 at an edge pops the head. rd_en with ready=0 is ignored.
- Full (level==DEPTH):
  - Write with simultaneous pop: accepted, level unchanged.
  - Write without pop: pixel dropped, overflow<=1, level unchanged.
  - If the dropped pixel carried eol, the line counters still update.
- Pointers wrap modulo DEPTH. level counts 0..DEPTH inclusive.
- Empty with simultaneous write: the head shows the written pixel after that edge; no bypass within the same cycle.
- rst overrides everything in the same edge.

Optional Feature:
- Macro: WCODER_LINE_SUM_EN.
- Defined: adds outputs line_sum [PIX_W+LCNT_W-1:0] and line_sum_valid [1].
  - Accumulator adds every captured pixel (including dropped ones).
  - At the eol commit edge: line_sum <= accumulator + committed pixel; line_sum_valid pulses 1 for one cycle; accumulator clears.
  - vsync and rst clear the accumulator. rst also clears line_sum.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset check: assert rst 2 cycles while toggling href/din -> ready=0, level=0, line_cnt=0, overflow=0, dout_sof=0 throughout and after.
- Frame of 3 lines x 21 pixels, din=pix+line+1, rd_en=1 constantly, DEPTH=32 -> 63 pops in order:
  - first pop 1 with dout_sof=1;
  - eol on values 21, 22, 23;
  - line_len=21 after each line; line_cnt=3; overflow=0.
- Overflow: rd_en=0, one 40-pixel line (din=0..39), DEPTH=32 -> level=32, overflow=1; the drain returns 0..31 with no eol on 31; line_len=40.
- Full with simultaneous read: fill to 32, then href line with rd_en=1 every cycle -> level stays 32, overflow stays 0, order preserved.
- vsync mid-line: vsync=1 after 5th pixel of line 1 -> 5th pixel has eol=1, line_cnt=0, next captured pixel has dout_sof=1.
- WCODER_LINE_SUM_EN: line of 21 pixels din=1..21 -> line_sum=231 with a single-cycle line_sum_valid at the eol commit edge.
